// File: rtl/pcs_tx_wide_pkg.sv
// pcs_tx_wide_pkg: shared 100BASE-X PCS definitions.
// Holds the 4b5b code-group constants, the transmit state encoding and the
// nibble encoder. The code groups are written MSB first on the wire.
package pcs_tx_wide_pkg;

    // 4b5b data code groups
    localparam logic [4:0] CODE_0 = 5'b11110;
    localparam logic [4:0] CODE_1 = 5'b01001;
    localparam logic [4:0] CODE_2 = 5'b10100;
    localparam logic [4:0] CODE_3 = 5'b10101;
    localparam logic [4:0] CODE_4 = 5'b01010;
    localparam logic [4:0] CODE_5 = 5'b01011;
    localparam logic [4:0] CODE_6 = 5'b01110;
    localparam logic [4:0] CODE_7 = 5'b01111;
    localparam logic [4:0] CODE_8 = 5'b10010;
    localparam logic [4:0] CODE_9 = 5'b10011;
    localparam logic [4:0] CODE_A = 5'b10110;
    localparam logic [4:0] CODE_B = 5'b10111;
    localparam logic [4:0] CODE_C = 5'b11010;
    localparam logic [4:0] CODE_D = 5'b11011;
    localparam logic [4:0] CODE_E = 5'b11100;
    localparam logic [4:0] CODE_F = 5'b11101;

    // Control code groups
    localparam logic [4:0] CODE_I = 5'b11111;
    localparam logic [4:0] CODE_J = 5'b11000;
    localparam logic [4:0] CODE_K = 5'b10001;
    localparam logic [4:0] CODE_T = 5'b01101;
    localparam logic [4:0] CODE_R = 5'b00111;
    localparam logic [4:0] CODE_H = 5'b00100;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_START_J = 4'd1,
        ST_START_K = 4'd2,
        ST_ERROR_J = 4'd3,
        ST_ERROR_K = 4'd4,
        ST_DATA    = 4'd5,
        ST_ERROR   = 4'd6,
        ST_END_T   = 4'd7,
        ST_END_R   = 4'd8
    } pcs_tx_state_t;

    function automatic logic [4:0] encode_4b5b(input logic [3:0] nib);
        logic [4:0] code;
        case (nib)
            4'h0: code = CODE_0;
            4'h1: code = CODE_1;
            4'h2: code = CODE_2;
            4'h3: code = CODE_3;
            4'h4: code = CODE_4;
            4'h5: code = CODE_5;
            4'h6: code = CODE_6;
            4'h7: code = CODE_7;
            4'h8: code = CODE_8;
            4'h9: code = CODE_9;
            4'hA: code = CODE_A;
            4'hB: code = CODE_B;
            4'hC: code = CODE_C;
            4'hD: code = CODE_D;
            4'hE: code = CODE_E;
            default: code = CODE_F;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/pcs_tx_wide_gearbox.sv
// pcs_tx_gearbox: 5-bit code groups in, WIDTH bits per clock out.
// Keeps up to 4 leftover bits in a residue buffer; requests a new group
// (ce) whenever fewer than WIDTH bits are buffered, which yields exactly
// WIDTH group loads every 5 clocks. bits[WIDTH-1] is the oldest wire bit.
module pcs_tx_gearbox
    import pcs_tx_wide_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [4:0]       code_group,
    output logic             ce,
    output logic [WIDTH-1:0] bits
);

    // Working vector: residue on top, room for one group below it.
    localparam int SW = WIDTH + 4;

    logic [2:0]       count_reg;
    logic [2:0]       count_next;
    logic [3:0]       residue_reg;
    logic [3:0]       residue_next;
    logic [WIDTH-1:0] bits_reg;
    logic [WIDTH-1:0] bits_next;
    logic [SW-1:0]    stream;
    logic [2:0]       shamt;

    // ce depends only on the buffered bit count, never on the inputs.
    assign ce = ({1'b0, count_reg} < 4'(WIDTH));

    // Place a loaded group directly behind the valid residue bits. A load only
    // happens while count < WIDTH, so the shift amount never underflows then.
    always_comb begin
        shamt  = 3'(WIDTH - 1) - count_reg;
        stream = {residue_reg, {WIDTH{1'b0}}};
        if (load) begin
            stream = stream | (SW'(code_group) << shamt);
        end
        residue_next = stream[3:0];
        count_next   = 3'({1'b0, count_reg} + (load ? 4'd5 : 4'd0) - 4'(WIDTH));
    end

    // The oldest WIDTH bits of the working vector form the next output word.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out
        assign bits_next[gi] = stream[SW - WIDTH + gi];
    end

    // Gearbox state; reset leaves the line idle (all ones) and requests a group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg   <= 3'd0;
            residue_reg <= 4'd0;
            bits_reg    <= '1;
        end else begin
            count_reg   <= count_next;
            residue_reg <= residue_next;
            bits_reg    <= bits_next;
        end
    end

    assign bits = bits_reg;

endmodule

// File: rtl/pcs_tx_wide.sv
// pcs_tx_wide: 100BASE-X PCS transmit path with a WIDTH-bit PMA interface.
// Encodes MII nibbles into 4b5b code groups framed by /J/K/ ... /T/R/,
// sends /H/ for errored nibbles and /I/ when idle or when the link is down.
// The MII strobe ce comes from the internal gearbox.
// Optional feature macro: PCS_TX_STATS_EN adds the frames/errors counters
// (and the CNT_WIDTH parameter that sizes them).
module pcs_tx_wide
    import pcs_tx_wide_pkg::*;
#(
    parameter int WIDTH = 1
`ifdef PCS_TX_STATS_EN
    ,
    parameter int CNT_WIDTH = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 ce,
    input  logic                 enable,
    input  logic [3:0]           data,
    input  logic                 err,
    input  logic                 link_status,
    output logic [WIDTH-1:0]     bits,
    output logic                 tx
`ifdef PCS_TX_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] frames,
    output logic [CNT_WIDTH-1:0] errors
`endif
);

    pcs_tx_state_t state_reg;
    pcs_tx_state_t state_next;
    logic [3:0]    last_data_reg;
    logic          tx_reg;
    logic          tx_next;
    logic [4:0]    code_group;

    // Choose the group for the current state and the next state from the
    // nibble sampled now; the emitted data lags the sampled nibble by one ce.
    always_comb begin
        state_next = state_reg;
        tx_next    = tx_reg;
        code_group = CODE_I;
        case (state_reg)
            ST_IDLE: begin
                code_group = CODE_I;
                tx_next    = 1'b0;
                if (enable) begin
                    state_next = err ? ST_ERROR_J : ST_START_J;
                end
            end
            ST_START_J: begin
                code_group = CODE_J;
                tx_next    = 1'b1;
                state_next = err ? ST_ERROR_K : ST_START_K;
            end
            ST_ERROR_J: begin
                code_group = CODE_J;
                tx_next    = 1'b1;
                state_next = ST_ERROR_K;
            end
            ST_ERROR_K: begin
                code_group = CODE_K;
                state_next = ST_ERROR;
            end
            ST_START_K, ST_DATA, ST_ERROR: begin
                if (state_reg == ST_START_K) begin
                    code_group = CODE_K;
                end else if (state_reg == ST_DATA) begin
                    code_group = encode_4b5b(last_data_reg);
                end else begin
                    code_group = CODE_H;
                end
                // Dropping enable ends the frame even if err is set.
                if (enable && err) begin
                    state_next = ST_ERROR;
                end else if (enable) begin
                    state_next = ST_DATA;
                end else begin
                    state_next = ST_END_T;
                end
            end
            ST_END_T: begin
                code_group = CODE_T;
                tx_next    = 1'b0;
                state_next = ST_END_R;
            end
            ST_END_R: begin
                code_group = CODE_R;
                state_next = ST_IDLE;
            end
            default: begin
                code_group = CODE_I;
                tx_next    = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
        // Link down overrides everything; already buffered bits still drain.
        if (!link_status) begin
            code_group = CODE_I;
            tx_next    = 1'b0;
            state_next = ST_IDLE;
        end
    end

    // Encoder state advances only on MII strobe edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            last_data_reg <= 4'd0;
            tx_reg        <= 1'b0;
        end else if (ce) begin
            state_reg     <= state_next;
            last_data_reg <= data;
            tx_reg        <= tx_next;
        end
    end

    assign tx = tx_reg;

    pcs_tx_gearbox #(
        .WIDTH(WIDTH)
    ) u_gearbox (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ce),
        .code_group (code_group),
        .ce         (ce),
        .bits       (bits)
    );

`ifdef PCS_TX_STATS_EN
    logic [CNT_WIDTH-1:0] frames_reg;
    logic [CNT_WIDTH-1:0] errors_reg;

    // Count frame ends and /H/ groups as they are handed to the gearbox.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_reg <= '0;
            errors_reg <= '0;
        end else if (ce) begin
            if (state_next == ST_END_T) begin
                frames_reg <= frames_reg + CNT_WIDTH'(1);
            end
            if (code_group == CODE_H) begin
                errors_reg <= errors_reg + CNT_WIDTH'(1);
            end
        end
    end

    assign frames = frames_reg;
    assign errors = errors_reg;
`endif

endmodule

// File: tb/tb_pcs_tx_wide.sv
// tb_pcs_tx_wide: directed self-checking bench for pcs_tx_wide.
// One instance per WIDTH 1..5 shares clock and reset; each scenario drives
// one instance while the others stay idle.
`timescale 1ns/1ps
module tb_pcs_tx_wide;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [5:1] en_v   = '0;
    logic [5:1] er_v   = '0;
    logic [5:1] link_v = '1;
    logic [3:0] dat_v [1:5];

    wire [5:1] ce_w;
    wire [5:1] tx_w;
    wire [4:0] bits_w [1:5];
`ifdef PCS_TX_STATS_EN
    wire [15:0] frames_w [1:5];
    wire [15:0] errors_w [1:5];
`endif

    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;
    int   cur    = 1;
    logic cap_on = 1'b0;
    logic stream_q [$];

    always #5 clk = ~clk;

    for (genvar gi = 1; gi <= 5; gi++) begin : g_dut
        wire [gi-1:0] b;
        assign bits_w[gi] = 5'(b);
        pcs_tx_wide #(
            .WIDTH(gi)
`ifdef PCS_TX_STATS_EN
            , .CNT_WIDTH(16)
`endif
        ) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .ce          (ce_w[gi]),
            .enable      (en_v[gi]),
            .data        (dat_v[gi]),
            .err         (er_v[gi]),
            .link_status (link_v[gi]),
            .bits        (b),
            .tx          (tx_w[gi])
`ifdef PCS_TX_STATS_EN
            , .frames    (frames_w[gi])
            , .errors    (errors_w[gi])
`endif
        );
    end

    // Serialise the selected instance's output, oldest bit first.
    always @(negedge clk) begin
        if (cap_on) begin
            for (int i = 4; i >= 0; i--) begin
                if (i < cur) stream_q.push_back(bits_w[cur][i]);
            end
        end
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one nibble to instance k on its next ce edge.
    task automatic send(input int k, input logic e, input logic r, input logic [3:0] d);
        int n;
        n = 0;
        while (ce_w[k] !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("ce_wait_w%0d", k), 40'(n < 10), 40'd1);
        en_v[k]  = e;
        er_v[k]  = r;
        dat_v[k] = d;
        @(posedge clk); #1;
    endtask

    // One WIDTH=5 clock: drive a nibble, then check the resulting word and tx.
    task automatic step5(input string tag, input logic e, input logic [3:0] d,
                         input logic [4:0] eb, input logic et);
        en_v[5]  = e;
        dat_v[5] = d;
        @(posedge clk); #1;
        check({tag, "_bits"}, 40'(bits_w[5]), 40'(eb));
        check({tag, "_tx"}, 40'(tx_w[5]), 40'(et));
    endtask

    task automatic frame5(input string tag);
        step5({tag, "_idle0"}, 1'b1, 4'h5, 5'b11111, 1'b0);
        step5({tag, "_J"},     1'b1, 4'h5, 5'b11000, 1'b1);
        step5({tag, "_K"},     1'b1, 4'hD, 5'b10001, 1'b1);
        step5({tag, "_D"},     1'b1, 4'hA, 5'b11011, 1'b1);
        step5({tag, "_A"},     1'b0, 4'h0, 5'b10110, 1'b1);
        step5({tag, "_T"},     1'b0, 4'h0, 5'b01101, 1'b0);
        step5({tag, "_R"},     1'b0, 4'h0, 5'b00111, 1'b0);
        step5({tag, "_idle1"}, 1'b0, 4'h0, 5'b11111, 1'b0);
    endtask

    // Locate the /J/ (first 0 is its third bit) and compare 8 groups after it.
    task automatic check_stream(input string tag, input logic [39:0] exp);
        int z;
        int ones_bad;
        int idx;
        logic [4:0] g;
        z = -1;
        ones_bad = 0;
        for (int i = 0; i < stream_q.size(); i++) begin
            if (stream_q[i] === 1'b0) begin
                z = i;
                break;
            end
        end
        check({tag, "_start_found"}, 40'(z >= 2), 40'd1);
        if (z >= 2) begin
            for (int i = 0; i < z - 2; i++) begin
                if (stream_q[i] !== 1'b1) ones_bad++;
            end
            check({tag, "_lead_idle"}, 40'(ones_bad), 40'd0);
            for (int gx = 0; gx < 8; gx++) begin
                for (int b = 0; b < 5; b++) begin
                    idx = z - 2 + gx * 5 + b;
                    g[4-b] = (idx < stream_q.size()) ? stream_q[idx] : 1'bx;
                end
                check($sformatf("%s_group%0d", tag, gx), 40'(g), 40'(exp[39 - gx*5 -: 5]));
            end
        end
    endtask

    task automatic start_capture(input int k);
        cur = k;
        stream_q.delete();
        cap_on = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ce_cnt [1:5];
        int w1_bad, w2_bad, bits_bad, tx_bad;
        for (int k = 1; k <= 5; k++) begin
            dat_v[k]  = 4'h0;
            ce_cnt[k] = 0;
        end
        w1_bad = 0; w2_bad = 0; bits_bad = 0; tx_bad = 0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("rst_bits_w%0d", k), 40'(bits_w[k]), 40'((1 << k) - 1));
            check($sformatf("rst_tx_w%0d", k), 40'(tx_w[k]), 40'd0);
            check($sformatf("rst_ce_w%0d", k), 40'(ce_w[k]), 40'd1);
        end
        rst_n = 1'b1;

        // Idle cadence: 50 cycles with enable low
        for (int c = 0; c < 50; c++) begin
            for (int k = 1; k <= 5; k++) if (ce_w[k] === 1'b1) ce_cnt[k]++;
            if (ce_w[1] !== ((c % 5) == 0)) w1_bad++;
            if (ce_w[2] !== ((c % 5) == 0 || (c % 5) == 2)) w2_bad++;
            if (bits_w[1][0] !== 1'b1) bits_bad++;
            if (tx_w[1] !== 1'b0) tx_bad++;
            @(posedge clk); #1;
        end
        check("w1_ce_pattern", 40'(w1_bad), 40'd0);
        check("w2_ce_pattern", 40'(w2_bad), 40'd0);
        check("w1_idle_bits", 40'(bits_bad), 40'd0);
        check("w1_idle_tx", 40'(tx_bad), 40'd0);
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("ce_count_w%0d", k), 40'(ce_cnt[k]), 40'(10 * k));
        end

        // WIDTH=5 frame, word by word
        frame5("w5");
`ifdef PCS_TX_STATS_EN
        check("w5_frames", 40'(frames_w[5]), 40'd1);
        check("w5_errors", 40'(errors_w[5]), 40'd0);
`endif

        // WIDTH=2 frame, serialized stream
        start_capture(2);
        send(2, 1'b1, 1'b0, 4'h5);
        send(2, 1'b1, 1'b0, 4'h5);
        send(2, 1'b1, 1'b0, 4'hD);
        send(2, 1'b1, 1'b0, 4'hA);
        send(2, 1'b0, 1'b0, 4'h0);
        repeat (60) @(posedge clk);
        #1 cap_on = 1'b0;
        check_stream("w2", {5'b11000, 5'b10001, 5'b11011, 5'b10110,
                            5'b01101, 5'b00111, 5'b11111, 5'b11111});
        check("w2_tx_end", 40'(tx_w[2]), 40'd0);

        // WIDTH=3 error on the first nibble
        start_capture(3);
        send(3, 1'b1, 1'b1, 4'h5);
        send(3, 1'b1, 1'b0, 4'h5);
        send(3, 1'b0, 1'b0, 4'h0);
        repeat (60) @(posedge clk);
        #1 cap_on = 1'b0;
        check_stream("w3", {5'b11000, 5'b10001, 5'b00100, 5'b01101,
                            5'b00111, 5'b11111, 5'b11111, 5'b11111});
`ifdef PCS_TX_STATS_EN
        check("w3_errors", 40'(errors_w[3]), 40'd1);
        check("w3_frames", 40'(frames_w[3]), 40'd1);
`endif

        // WIDTH=4 link drop during DATA
        start_capture(4);
        send(4, 1'b1, 1'b0, 4'h5);
        send(4, 1'b1, 1'b0, 4'h5);
        send(4, 1'b1, 1'b0, 4'hD);
        send(4, 1'b1, 1'b0, 4'hA);
        link_v[4] = 1'b0;
        send(4, 1'b1, 1'b0, 4'hA);
        send(4, 1'b1, 1'b0, 4'hA);
        send(4, 1'b0, 1'b0, 4'h0);
        repeat (60) @(posedge clk);
        #1 cap_on = 1'b0;
        check_stream("w4", {5'b11000, 5'b10001, 5'b11011, 5'b11111,
                            5'b11111, 5'b11111, 5'b11111, 5'b11111});
        check("w4_tx_linkdown", 40'(tx_w[4]), 40'd0);
`ifdef PCS_TX_STATS_EN
        check("w4_frames", 40'(frames_w[4]), 40'd0);
`endif

        // Asynchronous reset in the middle of a WIDTH=5 frame
        step5("w5r_idle0", 1'b1, 4'h5, 5'b11111, 1'b0);
        step5("w5r_J",     1'b1, 4'h5, 5'b11000, 1'b1);
        step5("w5r_K",     1'b1, 4'hD, 5'b10001, 1'b1);
        #2 rst_n = 1'b0;
        en_v[5] = 1'b0;
        #1;
        check("midrst_bits_w5", 40'(bits_w[5]), 40'h1f);
        check("midrst_tx_w5", 40'(tx_w[5]), 40'd0);
        check("midrst_ce_w5", 40'(ce_w[5]), 40'd1);
`ifdef PCS_TX_STATS_EN
        check("midrst_frames_w5", 40'(frames_w[5]), 40'd0);
        check("midrst_errors_w3", 40'(errors_w[3]), 40'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        frame5("w5_after_rst");
`ifdef PCS_TX_STATS_EN
        check("w5_after_rst_frames", 40'(frames_w[5]), 40'd1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pcs_tx_wide.md
# pcs_tx_wide

Parametrised 100BASE-X PCS transmit path: 4b5b-encodes MII nibbles and frames them with /J/K/ start and /T/R/ end delimiters, /H/ for errors, and /I/ when idle. Drives a PMA that takes WIDTH bits per clock (1–5) through an internal gearbox. The block generates its own MII clock enable instead of receiving one. It sits between the MAC-side MII and a multi-bit serializer, and replaces the single-bit transmit process in wider-datapath builds.

## Interface
- WIDTH, 1: PMA bits per clock; legal 1..5.
- CNT_WIDTH, 16: width of the statistics counters (used only with PCS_TX_STATS_EN).
- clk  in  1  single clock for MII and PMA sides.
- rst_n  in  1  reset, asynchronous, active-low.
- ce  out  1  MII nibble strobe; enable/data/err are sampled on clk edges where ce=1.
- enable  in  1  MII TX_EN.
- data  in  4  MII TXD.
- err  in  1  MII TX_ER.
- link_status  in  1  PMA link up; 0 forces idle.
- bits  out  WIDTH  PMA bits, registered; bits[WIDTH-1] is the oldest bit on the wire.
- tx  out  1  transmitting, registered; feeds crs/col.
- frames  out  CNT_WIDTH  frames sent (PCS_TX_STATS_EN only).
- errors  out  CNT_WIDTH  /H/ groups sent (PCS_TX_STATS_EN only).

## Operation
- Gearbox:
  - count is a 3-bit register holding the number of buffered bits, always in 0..4, plus a 4-bit residue buffer.
  - ce = (count < WIDTH). This is combinational from count only; there is no path from the inputs.
  - On ce: append the 5-bit code group after the residue.
  - Each cycle: emit the oldest WIDTH bits.
  - count_next = count + (ce ? 5 : 0) − WIDTH.
- Encoder: on each ce edge, register the sampled nibble as last_data and advance the state machine. The emitted code group is derived from last_data and the current state, giving one nibble of lookahead.
- States:
  - IDLE: emit /I/; tx←0. On enable go to START_J, or to ERROR_J if err.
  - START_J: emit /J/; tx←1. Go to ERROR_K if err, else START_K.
  - START_K: emit /K/.
  - ERROR_J: emit /J/; tx←1; go to ERROR_K.
  - ERROR_K: emit /K/; go to ERROR.
  - DATA: emit the 4b5b code of last_data.
  - ERROR: emit /H/.
  - END_T: emit /T/; tx←0; go to END_R.
  - END_R: emit /R/; go to IDLE.
- From START_K, DATA and ERROR the next state is:
  - ERROR if enable && err;
  - DATA if enable;
  - END_T otherwise.
- link_status=0 at a ce edge: state←IDLE, tx←0, emit /I/. Bits already in the residue drain normally; no group is truncated.
- State changes only on ce edges. tx updates on ce edges, plus on the link_status override.

## Timing
- Reset values:
  - bits = all 1s, tx = 0, count = 0, state = IDLE, frames = errors = 0.
  - ce = 1 during and immediately after reset.
- Latency: a nibble sampled at ce edge k is encoded at ce edge k+1. Its first bit appears on bits one clock after that edge.
- ce cadence: exactly WIDTH ce pulses per 5 clocks. Pattern from reset:
  - WIDTH=1: cycles 0, 5, 10, …
  - WIDTH=2: cycles 0, 2, 5, 7, 10, …
  - WIDTH=5: every cycle.
- Wire bit order is continuous across words; there are no gaps or duplicates in any WIDTH.
- rst_n asserted mid-frame: all state is cleared asynchronously and bits returns to all 1s at once. The partial frame is lost.
- enable dropping on the same ce as err: END_T takes priority and err is ignored.

## Configuration
- PCS_TX_STATS_EN defined:
  - frames increments on each entry to END_T.
  - errors increments on each /H/ appended.
  - Both wrap modulo 2^CNT_WIDTH and are reset by rst_n.
- PCS_TX_STATS_EN undefined: frames and errors ports and the counter logic are absent.

## Structure
- Shared header: 4b5b code-group constants (CODE_0..F, I, J, K, T, R, H) and the state encodings. Shared with pcs_rx.
- Sub-module pcs_tx_gearbox holds count, the residue buffer, the ce generation and the bits register. It takes a 5-bit code group and its load strobe.

## Test plan
- WIDTH=1, link up, enable=0 for 50 cycles -> bits constantly 1; ce high at cycles 0, 5, 10, …; tx=0.
- WIDTH=5, frame of nibbles 5, 5, D, A, then enable=0 -> words /J/ 11000, /K/ 10001, 11011, 10110, /T/ 01101, /R/ 00111, then 11111. tx high from /J/ through the cycle before /T/.
- WIDTH=2, same frame -> serialized stream bit-identical to the WIDTH=5 stream; ce at cycles 0, 2, 5, 7, …
- WIDTH=3, err=1 with enable on the first nibble -> /J/K/H/; errors=1 with PCS_TX_STATS_EN.
- WIDTH=4, link_status→0 during DATA -> current group completes, then /I/ only; tx=0; no /T/R/.
- Any WIDTH, rst_n pulsed mid-frame -> bits=1s and tx=0 asynchronously; frames and errors = 0; next frame encodes correctly.
